// File: rtl/sprite_motion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_motion_pkg
// Description : Game configuration that all sprite instances share. It holds
//               the visible screen size. The target and the torpedo each use
//               one sprite_motion instance. Collision between them is the AND
//               of their sprite_hit outputs, formed outside this block.
// Revision    : 1.0  initial release
// ============================================================================
package sprite_motion_pkg;

    // Visible raster area. The sprite origin must lie inside this area to be
    // reported as on-screen.
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

endpackage : sprite_motion_pkg
`default_nettype wire

// File: rtl/sprite_motion_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : strobe_gen
// Description : Free-running divider. The counter wraps modulo 2^WIDTH.
//               strobe is high in each cycle where the counter is zero.
// Ports       : clk    - clock
//               reset  - synchronous active-high reset (counter to 0)
//               strobe - one-cycle pulse once every 2^WIDTH cycles
// Revision    : 1.0  initial release
// ============================================================================
module strobe_gen #(
    parameter int WIDTH = 20
) (
    input  logic clk,
    input  logic reset,
    output logic strobe
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // The pulse is decoded from the count. Because of this, it is high in the
    // first cycle after reset.
    assign strobe = (r_count == '0);

endmodule : strobe_gen
`default_nettype wire

// File: rtl/sprite_motion.sv
`default_nettype none
// ============================================================================
// Module      : sprite_motion
// Description : Position and velocity registers for one sprite. The position
//               advances by the stored velocity on each divider strobe when
//               update is enabled. The block also gives an on-screen flag and
//               a registered raster hit test.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               sprite_write_xy/_x/_y   - load position (priority over motion)
//               sprite_write_dxy/_dx/_dy- load signed velocity
//               sprite_enable_update    - allow motion on strobe
//               pixel_x, pixel_y        - current raster coordinate
//               sprite_x, sprite_y      - current position
//               sprite_within_screen    - origin inside the visible area
//               sprite_hit              - raster inside sprite (1 cycle late)
// Revision    : 1.0  initial release
// ============================================================================
module sprite_motion
    import sprite_motion_pkg::*;
#(
    parameter int X_WIDTH          = 10,
    parameter int Y_WIDTH          = 10,
    parameter int DXY_WIDTH        = 3,
    parameter int SPRITE_W         = 8,
    parameter int SPRITE_H         = 8,
    parameter int STROBE_CNT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sprite_write_xy,
    input  logic [X_WIDTH-1:0]   sprite_write_x,
    input  logic [Y_WIDTH-1:0]   sprite_write_y,
    input  logic                 sprite_write_dxy,
    input  logic [DXY_WIDTH-1:0] sprite_write_dx,
    input  logic [DXY_WIDTH-1:0] sprite_write_dy,
    input  logic                 sprite_enable_update,
    input  logic [X_WIDTH-1:0]   pixel_x,
    input  logic [Y_WIDTH-1:0]   pixel_y,
    output logic [X_WIDTH-1:0]   sprite_x,
    output logic [Y_WIDTH-1:0]   sprite_y,
    output logic                 sprite_within_screen,
    output logic                 sprite_hit
);

    logic                 w_strobe;
    logic [X_WIDTH-1:0]   r_x;
    logic [Y_WIDTH-1:0]   r_y;
    logic [DXY_WIDTH-1:0] r_dx;
    logic [DXY_WIDTH-1:0] r_dy;
    logic                 r_hit;

    // The divider does not look at the write or enable inputs, so the
    // strobe phase depends only on the time since reset.
    strobe_gen #(
        .WIDTH (STROBE_CNT_WIDTH)
    ) u_strobe_gen (
        .clk    (clk),
        .reset  (reset),
        .strobe (w_strobe)
    );

    // Sign-extend the velocity to the position width. The add then wraps
    // naturally modulo 2^WIDTH.
    logic [X_WIDTH-1:0] w_dx_ext;
    logic [Y_WIDTH-1:0] w_dy_ext;
    assign w_dx_ext = {{(X_WIDTH-DXY_WIDTH){r_dx[DXY_WIDTH-1]}}, r_dx};
    assign w_dy_ext = {{(Y_WIDTH-DXY_WIDTH){r_dy[DXY_WIDTH-1]}}, r_dy};

    // A write load has priority over motion. Motion uses the velocity held
    // before any velocity write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (sprite_write_xy) begin
            r_x <= sprite_write_x;
            r_y <= sprite_write_y;
        end else if (w_strobe && sprite_enable_update) begin
            r_x <= r_x + w_dx_ext;
            r_y <= r_y + w_dy_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (sprite_write_dxy) begin
            r_dx <= sprite_write_dx;
            r_dy <= sprite_write_dy;
        end
    end

    // The hit rectangle is compared with one extra bit. A sprite near the
    // right or bottom edge therefore does not wrap back onto column or row 0.
    logic [X_WIDTH:0] w_sx, w_px, w_x_end;
    logic [Y_WIDTH:0] w_sy, w_py, w_y_end;
    logic             w_hit;
    assign w_sx    = {1'b0, r_x};
    assign w_px    = {1'b0, pixel_x};
    assign w_x_end = w_sx + (X_WIDTH+1)'(SPRITE_W);
    assign w_sy    = {1'b0, r_y};
    assign w_py    = {1'b0, pixel_y};
    assign w_y_end = w_sy + (Y_WIDTH+1)'(SPRITE_H);
    assign w_hit   = (w_sx <= w_px) && (w_px < w_x_end) &&
                     (w_sy <= w_py) && (w_py < w_y_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_hit;
        end
    end

    assign sprite_x   = r_x;
    assign sprite_y   = r_y;
    assign sprite_hit = r_hit;

    // A move left or up past zero wraps to a large value. Such a position
    // reads as off-screen.
    assign sprite_within_screen = (r_x < X_WIDTH'(SCREEN_WIDTH)) &&
                                  (r_y < Y_WIDTH'(SCREEN_HEIGHT));

endmodule : sprite_motion
`default_nettype wire

// File: tb/tb_sprite_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_motion
// Description : Directed bench for sprite_motion with a 4-cycle strobe
//               period. Stimulus pushes the expected outputs for the next
//               edge into a queue. A monitor pops each entry and compares it
//               on the falling edge of the cycle it is due.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_motion;

    logic       clk = 1'b0;
    logic       reset;
    logic       sprite_write_xy;
    logic [9:0] sprite_write_x;
    logic [9:0] sprite_write_y;
    logic       sprite_write_dxy;
    logic [2:0] sprite_write_dx;
    logic [2:0] sprite_write_dy;
    logic       sprite_enable_update;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic       sprite_within_screen;
    logic       sprite_hit;

    sprite_motion #(
        .X_WIDTH          (10),
        .Y_WIDTH          (10),
        .DXY_WIDTH        (3),
        .SPRITE_W         (8),
        .SPRITE_H         (8),
        .STROBE_CNT_WIDTH (2)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .sprite_write_xy      (sprite_write_xy),
        .sprite_write_x       (sprite_write_x),
        .sprite_write_y       (sprite_write_y),
        .sprite_write_dxy     (sprite_write_dxy),
        .sprite_write_dx      (sprite_write_dx),
        .sprite_write_dy      (sprite_write_dy),
        .sprite_enable_update (sprite_enable_update),
        .pixel_x              (pixel_x),
        .pixel_y              (pixel_y),
        .sprite_x             (sprite_x),
        .sprite_y             (sprite_y),
        .sprite_within_screen (sprite_within_screen),
        .sprite_hit           (sprite_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         due;
        logic [9:0] x;
        logic [9:0] y;
        logic       ws;
        logic       chk_hit;
        logic       hit;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every entry that is due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            total = total + 1;
            if (e.due != cyc) begin
                bad = bad + 1;
                $display("FAIL %s: check missed, due cycle %0d seen at %0d", e.name, e.due, cyc);
            end else if (sprite_x !== e.x || sprite_y !== e.y ||
                         sprite_within_screen !== e.ws ||
                         (e.chk_hit && sprite_hit !== e.hit)) begin
                bad = bad + 1;
                $display("FAIL %s: got x=%0d y=%0d ws=%0b hit=%0b, want x=%0d y=%0d ws=%0b hit=%0b%s",
                         e.name, sprite_x, sprite_y, sprite_within_screen, sprite_hit,
                         e.x, e.y, e.ws, e.hit, e.chk_hit ? "" : "(unchecked)");
            end
        end
    end

    // Queue the expected state after the next edge, then advance one cycle.
    task automatic st(input string n, input int x, input int y,
                      input bit ws, input bit chk, input bit hit);
        exp_t e;
        e.name = n; e.due = cyc + 1;
        e.x = 10'(x); e.y = 10'(y);
        e.ws = ws; e.chk_hit = chk; e.hit = hit;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_xy(input bit en, input int x, input int y);
        sprite_write_xy = en; sprite_write_x = 10'(x); sprite_write_y = 10'(y);
    endtask

    task automatic wr_dxy(input bit en, input int dx, input int dy);
        sprite_write_dxy = en; sprite_write_dx = 3'(dx); sprite_write_dy = 3'(dy);
    endtask

    task automatic pix(input int x, input int y);
        pixel_x = 10'(x); pixel_y = 10'(y);
    endtask

    initial begin
        reset = 1'b1;
        wr_xy(0, 0, 0);
        wr_dxy(0, 0, 0);
        sprite_enable_update = 1'b0;
        pix(0, 0);

        // Reset state. R is the second edge.
        st("rst0", 0, 0, 1, 1, 0);
        st("rst1", 0, 0, 1, 1, 0);
        reset = 1'b0;

        // Strobe cycle right after reset. The velocity written now is not
        // used yet. Strobe edges: R+1, R+5, R+9, ...
        wr_dxy(1, 1, 1);
        sprite_enable_update = 1'b1;
        st("post_rst_old_v", 0, 0, 1, 1, 1);          // R+1
        wr_dxy(0, 0, 0);
        for (int i = 0; i < 3; i++) st("hold_a", 0, 0, 1, 0, 0);
        st("first_move", 1, 1, 1, 0, 0);              // R+5

        // Load (100,50) and velocity (+1,-1).
        wr_xy(1, 100, 50);
        wr_dxy(1, 1, -1);
        st("load", 100, 50, 1, 0, 0);                 // R+6
        wr_xy(0, 0, 0);
        wr_dxy(0, 0, 0);
        st("hold_b", 100, 50, 1, 0, 0);
        st("hold_b", 100, 50, 1, 0, 0);
        st("move1", 101, 49, 1, 0, 0);                // R+9
        for (int i = 0; i < 3; i++) st("hold_c", 101, 49, 1, 0, 0);
        st("move2", 102, 48, 1, 0, 0);                // R+13
        for (int i = 0; i < 3; i++) st("hold_d", 102, 48, 1, 0, 0);

        // Write on a strobe edge wins over motion.
        wr_xy(1, 10, 10);
        st("priority", 10, 10, 1, 0, 0);              // R+17
        wr_xy(0, 0, 0);
        sprite_enable_update = 1'b0;
        for (int i = 0; i < 3; i++) st("hold_e", 10, 10, 1, 0, 0);
        st("en_off_strobe", 10, 10, 1, 0, 0);         // R+21

        // Left wrap past zero.
        wr_xy(1, 0, 20);
        wr_dxy(1, -1, 0);
        sprite_enable_update = 1'b1;
        st("load_wrap", 0, 20, 1, 0, 0);              // R+22
        wr_xy(0, 0, 0);
        wr_dxy(0, 0, 0);
        st("hold_f", 0, 20, 1, 0, 0);
        st("hold_f", 0, 20, 1, 0, 0);
        st("wrap_left", 1023, 20, 0, 0, 0);           // R+25

        // Hit rectangle, motion disabled.
        sprite_enable_update = 1'b0;
        wr_xy(1, 636, 100);
        pix(643, 107);
        st("hit_load", 636, 100, 1, 1, 0);            // hit from old position
        wr_xy(0, 0, 0);
        st("hit_corner_in", 636, 100, 1, 1, 1);
        pix(644, 107);
        st("hit_x_out", 636, 100, 1, 1, 0);
        pix(636, 100);
        st("hit_origin", 636, 100, 1, 1, 1);
        pix(643, 108);
        st("hit_y_out", 636, 100, 1, 1, 0);
        pix(635, 100);
        st("hit_left_out", 636, 100, 1, 1, 0);

        // Rectangle at the right edge must not wrap to column 0.
        wr_xy(1, 1020, 0);
        pix(2, 0);
        st("nowrap_load", 1020, 0, 0, 1, 0);
        wr_xy(0, 0, 0);
        st("nowrap_col2", 1020, 0, 0, 1, 0);
        pix(1023, 7);
        st("nowrap_edge_in", 1020, 0, 0, 1, 1);       // R+34

        // Reset in the middle of motion.
        wr_xy(1, 200, 200);
        wr_dxy(1, 1, 1);
        pix(200, 200);
        st("pre_rst_load", 200, 200, 1, 1, 0);        // R+35
        wr_xy(0, 0, 0);
        wr_dxy(0, 0, 0);
        sprite_enable_update = 1'b1;
        st("pre_rst_hit", 200, 200, 1, 1, 1);         // R+36
        st("pre_rst_move", 201, 201, 1, 1, 1);        // R+37
        for (int i = 0; i < 3; i++) st("pre_rst_hold", 201, 201, 1, 1, 0);
        reset = 1'b1;
        wr_xy(1, 5, 5);
        wr_dxy(1, 3, 3);
        st("rst_mid", 0, 0, 1, 1, 0);                 // R+41 = R'
        reset = 1'b0;
        wr_xy(0, 0, 0);
        wr_dxy(1, 1, 1);
        pix(0, 0);
        st("restart_old_v", 0, 0, 1, 1, 1);           // R'+1
        wr_dxy(0, 0, 0);
        for (int i = 0; i < 3; i++) st("restart_hold", 0, 0, 1, 0, 0);
        st("restart_move", 1, 1, 1, 0, 0);            // R'+5

        // Upward wrap past zero.
        wr_dxy(1, 0, -2);
        st("load_up", 1, 1, 1, 0, 0);
        wr_dxy(0, 0, 0);
        st("hold_g", 1, 1, 1, 0, 0);
        st("hold_g", 1, 1, 1, 0, 0);
        st("wrap_up", 1, 1023, 0, 0, 0);              // R'+9

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d checks left, want 0", q.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sprite_motion
`default_nettype wire
